// File: rtl/inport_ctrl_pkg.sv
// Flit format, FSM encoding and port limits for the router input-port controller.
package inport_ctrl_pkg;

    localparam int unsigned MAXPORT = 4;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned DEST_W  = 3;
    localparam int unsigned HDR_W   = TYPE_W + DEST_W;
    localparam int unsigned ERR_W   = 8;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_HEAD     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_XFER = 2'b10,
        S_DROP = 2'b11
    } state_e;

    // Top HDR_W bits of every flit: type, then destination (meaningful on heads).
    typedef struct packed {
        flit_type_e             ftype;
        logic [DEST_W-1:0]      dest;
    } flit_hdr_t;

endpackage

// File: rtl/define.sv
// Router-wide dimensions shared by every port controller: PORT is the highest
// output port index and PORTW + 1 is the width of an output port ID.
`ifndef PORT
`define PORT 4
`endif
`ifndef PORTW
`define PORTW 2
`endif

// File: rtl/inport_ctrl_flit_dec.sv
// Combinational decode of a flit header into head/tail flags and destination.
module inport_ctrl_flit_dec
    import inport_ctrl_pkg::*;
(
    input  logic [HDR_W-1:0]  hdr,
    output logic [DEST_W-1:0] dest,
    output logic              is_head,
    output logic              is_tail,
    output logic              dest_ok
);

    flit_hdr_t h;

    assign h       = flit_hdr_t'(hdr);
    assign dest    = h.dest;
    assign is_head = (h.ftype == FT_HEAD) || (h.ftype == FT_HEADTAIL);
    assign is_tail = (h.ftype == FT_TAIL) || (h.ftype == FT_HEADTAIL);
    assign dest_ok = (h.dest <= DEST_W'(MAXPORT));

endmodule

// File: rtl/inport_ctrl.sv
// Router input-port controller: requests an output port for each packet and
// streams it through the crossbar. Define INPORT_ERRCNT_EN to build err_cnt.
`ifndef PORT
`define PORT 4
`endif
`ifndef PORTW
`define PORTW 2
`endif

module inport_ctrl
    import inport_ctrl_pkg::*;
#(
    parameter int unsigned FLITW = 32
)
(
    input  logic               clk,
    input  logic               rst_,
    input  logic [FLITW-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [`PORTW:0]    port,
    output logic               req,
    input  logic [`PORT:0]     grt_in,
    output logic [FLITW-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int unsigned PORT_ID_W = `PORTW + 1;

    state_e            state;
    logic [DEST_W-1:0] dest;
    logic              is_head;
    logic              is_tail;
    logic              dest_ok;

    inport_ctrl_flit_dec u_flit_dec (
        .hdr     (in_data[FLITW-1 -: HDR_W]),
        .dest    (dest),
        .is_head (is_head),
        .is_tail (is_tail),
        .dest_ok (dest_ok)
    );

    // State, requested port and request line.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= S_IDLE;
            req   <= 1'b0;
            port  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && is_head) begin
                        if (dest_ok) begin
                            state <= S_REQ;
                            req   <= 1'b1;
                            port  <= PORT_ID_W'(dest);
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                S_REQ: begin
                    if (grt_in[port]) begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Grant is ignored here; req stays up until the tail leaves.
                    if (in_valid && out_ready && is_tail) begin
                        state <= S_IDLE;
                        req   <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (in_valid && is_tail) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pop strobe and crossbar handshake; stray flits in IDLE are popped at once.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (!rst_) begin
            case (state)
                S_IDLE: in_ready = in_valid && !is_head;
                S_XFER: begin
                    out_data  = in_data;
                    out_valid = in_valid;
                    in_ready  = out_ready;
                end
                S_DROP: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

`ifdef INPORT_ERRCNT_EN
    logic drop_c;

    assign drop_c = in_valid && in_ready && ((state == S_IDLE) || (state == S_DROP));

    // Saturating count of discarded flits.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            err_cnt <= '0;
        end else if (drop_c && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_inport_ctrl.sv
// Bench for inport_ctrl: directed timing scenarios, then randomized packet
// traffic checked by a scoreboard of expected deliveries and drops.
`ifndef PORT
`define PORT 4
`endif
`ifndef PORTW
`define PORTW 2
`endif

module tb_inport_ctrl;
    import inport_ctrl_pkg::*;

    localparam int unsigned FLITW = 32;
`ifdef INPORT_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_;
    logic [FLITW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [`PORTW:0]  port;
    logic             req;
    logic [`PORT:0]   grt_in;
    logic [FLITW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       err_cnt;

    inport_ctrl #(.FLITW(FLITW)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .port      (port),
        .req       (req),
        .grt_in    (grt_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] flit; bit deliver; } src_t;
    typedef struct { logic [31:0] flit; logic [2:0] dest; } out_t;

    src_t src_q[$];
    out_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_drops = 0;
    bit   mon_en = 1'b0;
    bit   fire_in = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] d);
        return {t, d, 27'($urandom)};
    endfunction

    function automatic logic [31:0] exp_err(input int drops);
        if (!ERRCNT_EN) return 32'd0;
        return (drops > 255) ? 32'd255 : 32'(drops);
    endfunction

    // Scoreboard monitor: every pop is either the next expected delivery or a drop.
    always @(negedge clk) begin : monitor
        out_t e;
        if (mon_en) begin
            fire_in = in_valid && in_ready;
            chk("err_cnt", 32'(err_cnt), exp_err(exp_drops));
            if (req) begin
                if (exp_q.size() == 0) chk("req_without_packet", 32'(req), 32'd0);
                else chk("req_port", 32'(port), 32'(exp_q[0].dest));
            end
            if (out_valid && out_ready) begin
                chk("out_has_req", 32'(req), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.flit);
                end
            end else if (fire_in) begin
                chk("drop_expected", 32'(src_q.size() > 0 && !src_q[0].deliver), 32'd1);
                exp_drops++;
            end
        end
    end

    task automatic gen_traffic(input int npkt);
        int kind;
        int nb;
        bit good;
        logic [2:0] d;
        logic [31:0] f;
        for (int p = 0; p < npkt; p++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                f = mk(($urandom_range(0, 1) != 0) ? FT_BODY : FT_TAIL, 3'($urandom));
                src_q.push_back('{f, 1'b0});
            end else begin
                good = (kind != 1);
                d = good ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                nb = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 3);
                for (int k = -1; k <= nb + 1; k++) begin
                    if (nb < 0) f = mk(FT_HEADTAIL, d);
                    else if (k == -1) f = mk(FT_HEAD, d);
                    else if (k == nb + 1) f = mk(FT_TAIL, 3'($urandom));
                    else f = mk(FT_BODY, 3'($urandom));
                    src_q.push_back('{f, good});
                    if (good) exp_q.push_back('{f, d});
                    if (nb < 0) break;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] f;
        int cyc;

        rst_ = 1'b1; in_valid = 1'b1; in_data = mk(FT_BODY, 3'd0);
        out_ready = 1'b0; grt_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_port", 32'(port), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_ = 1'b0; in_valid = 1'b0;

        // Single-flit packet to port 3 with grant one cycle after req.
        @(posedge clk); #1;
        f = mk(FT_HEADTAIL, 3'd3); in_data = f; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("a_req_low_idle", 32'(req), 32'd0);
        chk("a_no_pop_idle", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("a_req_rise", 32'(req), 32'd1);
        chk("a_port", 32'(port), 32'd3);
        chk("a_req_out_valid", 32'(out_valid), 32'd0);
        chk("a_req_in_ready", 32'(in_ready), 32'd0);
        grt_in = 5'b01000;
        @(posedge clk); #1;
        grt_in = '0;
        @(negedge clk);
        chk("a_out_valid", 32'(out_valid), 32'd1);
        chk("a_out_data", out_data, f);
        chk("a_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("a_req_drop", 32'(req), 32'd0);
        chk("a_out_idle", 32'(out_valid), 32'd0);

        // Withheld grant (other outputs granting), then reset mid-packet.
        @(posedge clk); #1;
        f = mk(FT_HEAD, 3'd2); in_data = f; in_valid = 1'b1; out_ready = 1'b1;
        grt_in = 5'b11011;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b_wait_req", 32'(req), 32'd1);
            chk("b_wait_port", 32'(port), 32'd2);
            chk("b_wait_in_ready", 32'(in_ready), 32'd0);
            chk("b_wait_out_valid", 32'(out_valid), 32'd0);
        end
        grt_in = 5'b00100;
        @(posedge clk); #1;
        grt_in = '0;
        @(negedge clk);
        chk("b_out_valid", 32'(out_valid), 32'd1);
        chk("b_out_data", out_data, f);
        @(posedge clk); #1;
        in_data = mk(FT_BODY, 3'd0); out_ready = 1'b0;
        @(negedge clk);
        chk("b_req_held", 32'(req), 32'd1);
        chk("b_stall_in_ready", 32'(in_ready), 32'd0);
        #1 rst_ = 1'b1;
        #1;
        chk("b_rst_req", 32'(req), 32'd0);
        chk("b_rst_out_valid", 32'(out_valid), 32'd0);
        chk("b_rst_in_ready", 32'(in_ready), 32'd0);
        #1 rst_ = 1'b0;
        @(posedge clk); #1;
        in_data = mk(FT_TAIL, 3'd0);
        @(negedge clk);
        chk("b_stray_tail_pop", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b_err_cnt", 32'(err_cnt), exp_err(2));
        chk("b_req_idle", 32'(req), 32'd0);

        // Randomized traffic, enough drops to reach counter saturation.
        #1 rst_ = 1'b1;
        @(posedge clk); #1;
        rst_ = 1'b0;
        gen_traffic(400);
        exp_drops = 0;
        fire_in = 1'b0;
        mon_en = 1'b1;
        cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 30000) begin
            @(posedge clk); #1;
            if (fire_in && src_q.size() > 0) void'(src_q.pop_front());
            in_valid  = (src_q.size() > 0) && ($urandom_range(0, 5) != 0);
            in_data   = (src_q.size() > 0) ? src_q[0].flit : 32'h0;
            out_ready = ($urandom_range(0, 2) != 0);
            grt_in    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        chk("drain_src", 32'(src_q.size()), 32'd0);
        chk("drain_exp", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
